// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arb_pkg: shared types, constants and counter helper for axi_rd_arbiter
package axi_rd_arb_pkg;
    localparam int AR_ID_W   = 4;
    localparam int AR_ADDR_W = 32;
    localparam int CNT_W     = 4;
    localparam logic PORT_IFU = 1'b0;
    localparam logic PORT_LSU = 1'b1;

    typedef enum logic {IDLE, ISSUE} arb_state_e;

    typedef struct packed {
        logic [AR_ID_W-1:0]   id;
        logic [AR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [2:0]           prot;
        logic [3:0]           qos;
    } ar_req_t;

    // simultaneous inc/dec cancel; a stray decrement at zero is absorbed
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic inc, input logic dec);
        return (inc == dec) ? cnt : inc ? cnt + CNT_W'(1) : (cnt == '0) ? cnt : cnt - CNT_W'(1);
    endfunction
endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: one AXI4 read port (AR + R channels)
interface axi_rd_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arprot, arqos, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arprot, arqos, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; with AXI_RD_ARB_QOS_EN strictly higher QoS wins contention
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
`ifdef AXI_RD_ARB_QOS_EN
    input  logic [3:0] qos0,
    input  logic [3:0] qos1,
`endif
    output logic       grant_idx,
    output logic       grant_vld
);
    // a lone requester wins outright; contention goes to higher QoS (if enabled), else the preferred port
    always_comb begin
        grant_vld = |req;
`ifdef AXI_RD_ARB_QOS_EN
        grant_idx = !(&req) ? req[1] : (qos1 != qos0) ? (qos1 > qos0) : prio;
`else
        grant_idx = (&req) ? prio : req[1];
`endif
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read port between IFU (port 0) and LSU (port 1)
// Optional macro AXI_RD_ARB_QOS_EN: higher arqos wins when both ports are eligible
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int ID_W    = AR_ID_W,
    parameter int ADDR_W  = AR_ADDR_W,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input logic             clk,
    input logic             rst,
    axi_rd_arbiter_if.slave s0,
    axi_rd_arbiter_if.slave s1,
    axi_rd_arbiter_if.master m
);
    localparam logic [0:0]       ST_IDLE  = IDLE;
    localparam logic [0:0]       ST_ISSUE = ISSUE;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

    logic [0:0]        state;
    logic              gnt, prio, grant_idx, grant_vld, ar_done, r_idx, r_done;
    logic [CNT_W-1:0]  cnt0, cnt1;
    logic [DATA_W-1:0] rdata;
    ar_req_t           q, req0, req1;

    assign req0 = '{id: s0.arid, addr: s0.araddr, len: s0.arlen, size: s0.arsize,
                    burst: s0.arburst, prot: s0.arprot, qos: s0.arqos};
    assign req1 = '{id: s1.arid, addr: s1.araddr, len: s1.arlen, size: s1.arsize,
                    burst: s1.arburst, prot: s1.arprot, qos: s1.arqos};

    rr_arb2 u_arb (
        .req      ({s1.arvalid && cnt1 < CNT_MAX, s0.arvalid && cnt0 < CNT_MAX}),
        .prio     (prio),
`ifdef AXI_RD_ARB_QOS_EN
        .qos0     (s0.arqos),
        .qos1     (s1.arqos),
`endif
        .grant_idx(grant_idx),
        .grant_vld(grant_vld)
    );

    assign ar_done    = (state == ST_ISSUE) && m.arready;
    assign m.arvalid  = (state == ST_ISSUE);
    assign m.arid     = {gnt, ID_W'(q.id)};
    assign m.araddr   = ADDR_W'(q.addr);
    assign m.arlen    = q.len;
    assign m.arsize   = q.size;
    assign m.arburst  = q.burst;
    assign m.arprot   = q.prot;
    assign m.arqos    = q.qos;
    assign s0.arready = ar_done && (gnt == PORT_IFU);
    assign s1.arready = ar_done && (gnt == PORT_LSU);

    assign r_idx      = m.rid[ID_W];
    assign r_done     = m.rvalid && m.rready && m.rlast;
    assign rdata      = m.rdata;
    assign m.rready   = (r_idx == PORT_LSU) ? s1.rready : s0.rready;
    assign s0.rvalid  = m.rvalid && (r_idx == PORT_IFU);
    assign s1.rvalid  = m.rvalid && (r_idx == PORT_LSU);
    assign s0.rid     = m.rid[ID_W-1:0];
    assign s1.rid     = m.rid[ID_W-1:0];
    assign s0.rdata   = rdata;
    assign s1.rdata   = rdata;
    assign s0.rresp   = m.rresp;
    assign s1.rresp   = m.rresp;
    assign s0.rlast   = m.rlast;
    assign s1.rlast   = m.rlast;

    // AR FSM: latch the winner in IDLE, hold it on the downstream AR until accepted;
    // prio points at the port that did not win last, so port 0 is preferred after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= 1'b0;
            prio  <= 1'b0;
            q     <= '0;
        end else if (state == ST_IDLE) begin
            if (grant_vld) begin
                state <= ST_ISSUE;
                gnt   <= grant_idx;
                q     <= grant_idx ? req1 : req0;
            end
        end else if (m.arready) begin
            state <= ST_IDLE;
            prio  <= ~gnt;
        end
    end

    // per-port outstanding bursts: +1 on downstream AR accept, -1 on the last R beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt_next(cnt0, ar_done && gnt == PORT_IFU, r_done && r_idx == PORT_IFU);
            cnt1 <= cnt_next(cnt1, ar_done && gnt == PORT_LSU, r_done && r_idx == PORT_LSU);
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed, table-driven and randomized checks of axi_rd_arbiter
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s0 ();
    axi_rd_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s1 ();
    axi_rd_arbiter_if #(.ID_W(ID_W + 1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

    axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .s0(s0), .s1(s1), .m(m)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int gq[$];

    typedef struct {
        logic [4:0] rid;
        logic       rvalid, rlast, r0, r1;
        logic       e_v0, e_v1, e_rready;
        logic [3:0] e_rid;
    } vec_t;
    vec_t vt[7];

    typedef struct {
        logic tag;
        int   beats;
    } burst_t;
    burst_t rq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input int p, input logic v, input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len, input logic [3:0] qos);
        if (p == 0) begin
            s0.arvalid = v; s0.araddr = a; s0.arid = id; s0.arlen = len; s0.arqos = qos;
            s0.arsize = 3'd2; s0.arburst = 2'd1; s0.arprot = 3'd0;
        end else begin
            s1.arvalid = v; s1.araddr = a; s1.arid = id; s1.arlen = len; s1.arqos = qos;
            s1.arsize = 3'd2; s1.arburst = 2'd1; s1.arprot = 3'd0;
        end
    endtask

    function automatic logic ar_rdy(input int p);
        return (p == 0) ? s0.arready : s1.arready;
    endfunction

    task automatic idle_inputs();
        set_ar(0, 1'b0, '0, '0, '0, '0);
        set_ar(1, 1'b0, '0, '0, '0, '0);
        s0.rready = 1'b0; s1.rready = 1'b0;
        m.arready = 1'b0; m.rvalid = 1'b0; m.rid = '0; m.rdata = '0; m.rresp = '0; m.rlast = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_one(input int p, input logic [31:0] a);
        bit done = 0;
        set_ar(p, 1'b1, a, 4'h1, 8'd0, 4'd0);
        m.arready = 1'b1;
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            if (ar_rdy(p)) done = 1;
            tick();
        end
        set_ar(p, 1'b0, a, 4'h1, 8'd0, 4'd0);
        chk($sformatf("issue_one_p%0d_done", p), done, 1'b1);
    endtask

    task automatic collect(input int n, input int budget);
        gq.delete();
        for (int c = 0; c < budget && gq.size() < n; c++) begin
            #1;
            if (m.arvalid && m.arready) gq.push_back(int'(m.arid[ID_W]));
            tick();
        end
        chk("collect_count", gq.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // R routing vectors: rid, rvalid, rlast, s0_rready, s1_rready | s0_rvalid, s1_rvalid, m_rready, s_rid
        vt[0] = '{5'h07, 1, 0, 1, 0, 1, 0, 1, 4'h7};
        vt[1] = '{5'h13, 1, 1, 1, 0, 0, 1, 0, 4'h3};
        vt[2] = '{5'h1A, 1, 0, 0, 1, 0, 1, 1, 4'hA};
        vt[3] = '{5'h02, 1, 1, 0, 1, 1, 0, 0, 4'h2};
        vt[4] = '{5'h1F, 0, 0, 1, 1, 0, 0, 1, 4'hF};
        vt[5] = '{5'h00, 0, 1, 0, 0, 0, 0, 0, 4'h0};
        vt[6] = '{5'h01, 1, 1, 1, 0, 1, 0, 1, 4'h1};

        // reset state
        do_reset();
        #1;
        chk("rst_m_arvalid", m.arvalid, 1'b0);
        chk("rst_s_arready", {s1.arready, s0.arready}, 2'b00);
        chk("rst_s_rvalid", {s1.rvalid, s0.rvalid}, 2'b00);
        chk("rst_cnt", {dut.cnt1, dut.cnt0}, 8'h00);

        // table-driven R path
        foreach (vt[i]) begin
            m.rid = vt[i].rid; m.rvalid = vt[i].rvalid; m.rlast = vt[i].rlast;
            s0.rready = vt[i].r0; s1.rready = vt[i].r1;
            m.rdata = $urandom; m.rresp = 2'(i);
            #1;
            chk($sformatf("vec%0d_route", i), {s0.rvalid, s1.rvalid, m.rready}, {vt[i].e_v0, vt[i].e_v1, vt[i].e_rready});
            chk($sformatf("vec%0d_rid", i), {s0.rid, s1.rid}, {vt[i].e_rid, vt[i].e_rid});
            chk($sformatf("vec%0d_data", i), {s0.rdata, s1.rdata, s0.rresp, s0.rlast},
                {m.rdata, m.rdata, 2'(i), vt[i].rlast});
            tick();
        end
        idle_inputs();
        #1;
        chk("cnt_zero_hold", {dut.cnt1, dut.cnt0}, 8'h00);

        // test 1: single request from port 0
        do_reset();
        set_ar(0, 1'b1, 32'h8000_0000, 4'h5, 8'd3, 4'd0);
        m.arready = 1'b1;
        #1;
        chk("t1_c1_arvalid", m.arvalid, 1'b0);
        chk("t1_c1_arready", s0.arready, 1'b0);
        tick();
        chk("t1_c2_arvalid", m.arvalid, 1'b1);
        chk("t1_c2_araddr", m.araddr, 32'h8000_0000);
        chk("t1_c2_arid", m.arid, 5'h05);
        chk("t1_c2_attr", {m.arlen, m.arsize, m.arburst}, {8'd3, 3'd2, 2'd1});
        chk("t1_c2_arready", {s1.arready, s0.arready}, 2'b01);
        tick();
        set_ar(0, 1'b0, '0, '0, '0, '0);
        #1;
        chk("t1_cnt0", dut.cnt0, 4'd1);
        chk("t1_c3_arvalid", m.arvalid, 1'b0);

        // test 2: continuous contention alternates
        do_reset();
        set_ar(0, 1'b1, 32'h100, 4'h1, 8'd0, 4'd0);
        set_ar(1, 1'b1, 32'h200, 4'h2, 8'd0, 4'd0);
        m.arready = 1'b1;
        collect(8, 40);
        foreach (gq[i]) chk($sformatf("t2_grant%0d", i), gq[i], i % 2);
        idle_inputs();

        // test 3: MAX_OUT bound on port 0
        do_reset();
        set_ar(0, 1'b1, 32'h300, 4'h3, 8'd0, 4'd0);
        m.arready = 1'b1;
        collect(MAX_OUT, 30);
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                #1;
                seen |= s0.arready | m.arvalid;
                tick();
            end
            chk("t3_blocked", seen, 1'b0);
        end
        chk("t3_cnt0_max", dut.cnt0, 4'(MAX_OUT));
        m.rid = 5'h03; m.rvalid = 1'b1; m.rlast = 1'b1; s0.rready = 1'b1;
        #1;
        chk("t3_r_route", {s0.rvalid, s1.rvalid, m.rready}, 3'b101);
        tick();
        m.rvalid = 1'b0; m.rlast = 1'b0;
        chk("t3_cnt0_dec", dut.cnt0, 4'(MAX_OUT - 1));
        chk("t3_idle_cycle", m.arvalid, 1'b0);
        tick();
        chk("t3_fifth_issue", {m.arvalid, s0.arready}, 2'b11);
        tick();
        idle_inputs();

        // test 4: R to port 1 with back-pressure
        do_reset();
        issue_one(1, 32'h400);
        chk("t4_cnt1", dut.cnt1, 4'd1);
        m.rid = {1'b1, 4'h3}; m.rvalid = 1'b1; m.rlast = 1'b1; s1.rready = 1'b0; s0.rready = 1'b1;
        #1;
        chk("t4_route", {s1.rvalid, s0.rvalid, m.rready}, 3'b100);
        chk("t4_rid", s1.rid, 4'h3);
        tick();
        chk("t4_cnt1_held", dut.cnt1, 4'd1);
        s1.rready = 1'b1;
        #1;
        chk("t4_rready", m.rready, 1'b1);
        tick();
        m.rvalid = 1'b0;
        chk("t4_cnt1_dec", dut.cnt1, 4'd0);
        idle_inputs();

        // test 5: same-cycle inc/dec, then reset in ISSUE
        do_reset();
        issue_one(0, 32'h500);
        issue_one(0, 32'h504);
        chk("t5_cnt0_2", dut.cnt0, 4'd2);
        set_ar(0, 1'b1, 32'h508, 4'h4, 8'd0, 4'd0);
        m.arready = 1'b1;
        tick();
        m.rid = 5'h04; m.rvalid = 1'b1; m.rlast = 1'b1; s0.rready = 1'b1;
        #1;
        chk("t5_both", {s0.arready, m.rready}, 2'b11);
        tick();
        set_ar(0, 1'b0, '0, '0, '0, '0);
        m.rvalid = 1'b0;
        #1;
        chk("t5_cnt0_same", dut.cnt0, 4'd2);
        m.arready = 1'b0;
        set_ar(0, 1'b1, 32'h50C, 4'h4, 8'd0, 4'd0);
        tick();
        chk("t5_in_issue", m.arvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_async_arvalid", m.arvalid, 1'b0);
        chk("t5_async_cnt", {dut.cnt1, dut.cnt0}, 8'h00);
        tick();
        chk("t5_rst_edge_arvalid", m.arvalid, 1'b0);
        rst = 1'b0;
        idle_inputs();

        // test 6: QoS (or plain round-robin without the macro)
        do_reset();
        set_ar(0, 1'b1, 32'h600, 4'h6, 8'd0, 4'd2);
        set_ar(1, 1'b1, 32'h700, 4'h7, 8'd0, 4'd9);
        m.arready = 1'b1;
        collect(3, 20);
        foreach (gq[i]) begin
`ifdef AXI_RD_ARB_QOS_EN
            chk($sformatf("t6_qos_grant%0d", i), gq[i], 1);
`else
            chk($sformatf("t6_rr_grant%0d", i), gq[i], i % 2);
`endif
        end
        idle_inputs();

        // randomized traffic against a transaction-level model
        do_reset();
        begin
            logic        pend[2] = '{0, 0};
            logic [3:0]  r_id[2];
            logic [31:0] r_addr[2];
            logic [7:0]  r_len[2];
            logic [3:0]  r_qos[2];
            int          mcnt[2] = '{0, 0};
            logic        stall = 1'b0;
            logic [4:0]  st_id;
            logic [31:0] st_addr;
            int          cyc = 0;
            while (cyc < 3500 && (cyc < 2000 || pend[0] || pend[1] || rq.size() != 0)) begin
                logic ar_hs, r_hs, r_last;
                int   p, idx;
                for (int k = 0; k < 2; k++) begin
                    if (!pend[k] && cyc < 2000 && $urandom_range(0, 2) == 0) begin
                        pend[k] = 1'b1;
                        r_id[k] = 4'($urandom);
                        r_addr[k] = $urandom;
                        r_len[k] = 8'($urandom_range(0, 3));
                        r_qos[k] = 4'($urandom);
                    end
                    set_ar(k, pend[k], r_addr[k], r_id[k], r_len[k], r_qos[k]);
                end
                m.arready = (cyc >= 2000) ? 1'b1 : 1'($urandom_range(0, 1));
                if (!m.rvalid && rq.size() != 0 && $urandom_range(0, 1) == 1) begin
                    m.rvalid = 1'b1;
                    m.rid = {rq[0].tag, 4'($urandom)};
                    m.rdata = $urandom;
                    m.rlast = (rq[0].beats == 1);
                end
                s0.rready = (cyc >= 2000) ? 1'b1 : 1'($urandom_range(0, 1));
                s1.rready = (cyc >= 2000) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                idx = int'(m.rid[ID_W]);
                if (m.rvalid) begin
                    chk("rnd_rvalid", {s1.rvalid, s0.rvalid}, (idx == 1) ? 2'b10 : 2'b01);
                    chk("rnd_rid", (idx == 1) ? s1.rid : s0.rid, m.rid[3:0]);
                    chk("rnd_rdata", (idx == 1) ? s1.rdata : s0.rdata, m.rdata);
                    chk("rnd_rready", m.rready, (idx == 1) ? s1.rready : s0.rready);
                end else
                    chk("rnd_rvalid_idle", {s1.rvalid, s0.rvalid}, 2'b00);
                if (stall) chk("rnd_ar_stable", {m.arvalid, m.arid, m.araddr}, {1'b1, st_id, st_addr});
                ar_hs = m.arvalid && m.arready;
                p = int'(m.arid[ID_W]);
                if (ar_hs) begin
                    chk("rnd_pending", pend[p], 1'b1);
                    chk("rnd_arready", {s1.arready, s0.arready}, (p == 1) ? 2'b10 : 2'b01);
                    chk("rnd_fields", {m.arid[3:0], m.araddr, m.arlen, m.arqos},
                        {r_id[p], r_addr[p], r_len[p], r_qos[p]});
                    chk("rnd_bound", mcnt[p] < MAX_OUT, 1'b1);
                end else
                    chk("rnd_arready_idle", {s1.arready, s0.arready}, 2'b00);
                stall = m.arvalid && !m.arready;
                st_id = m.arid;
                st_addr = m.araddr;
                r_hs = m.rvalid && m.rready;
                r_last = m.rlast;
                tick();
                if (r_hs) begin
                    m.rvalid = 1'b0;
                    rq[0].beats--;
                    if (r_last) begin
                        mcnt[idx]--;
                        void'(rq.pop_front());
                    end
                end
                if (ar_hs) begin
                    mcnt[p]++;
                    pend[p] = 1'b0;
                    rq.push_back('{tag: 1'(p), beats: int'(r_len[p]) + 1});
                end
                chk("rnd_cnt", {dut.cnt1, dut.cnt0}, {4'(mcnt[1]), 4'(mcnt[0])});
                cyc++;
            end
            chk("rnd_drained", {pend[0], pend[1], rq.size() == 0}, 3'b001);
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
